ysyx_22041211_lsu: RTL and testbench

Multicycle load/store unit sitting between the execute stage and `ysyx_22041211_wb`. It accepts one instruction at a time over a valid/ready handshake and, for memory instructions, drives a request/grant/rvalid memory port. Load data is aligned and extended here. It presents `wd`/`wreg`/`wdata` to writeback over a second valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

---
 rtl/ysyx_22041211_lsu_if.sv | 45 ++++
 rtl/ysyx_22041211_lsu.sv | 199 +++++++++++++++++++
 tb/tb_ysyx_22041211_lsu.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041211_lsu_if.sv
// Bundle of the LSU's execute-side, memory-side and writeback-side handshakes.
// The slave modport is the LSU itself; master is the surrounding pipeline/memory.
interface ysyx_22041211_lsu_if #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
);
    logic                in_valid_i;
    logic                in_ready_o;
    logic                wd_i;
    logic [4:0]          wreg_i;
    logic [DATA_LEN-1:0] alu_result_i;
    logic [DATA_LEN-1:0] mem_wdata_i;
    logic [2:0]          load_type_i;
    logic [1:0]          store_type_i;

    logic                mem_req_o;
    logic                mem_we_o;
    logic [ADDR_LEN-1:0] mem_addr_o;
    logic [DATA_LEN-1:0] mem_wdata_o;
    logic [3:0]          mem_wstrb_o;
    logic                mem_gnt_i;
    logic                mem_rvalid_i;
    logic [DATA_LEN-1:0] mem_rdata_i;

    logic                out_valid_o;
    logic                out_ready_i;
    logic                wd_o;
    logic [4:0]          wreg_o;
    logic [DATA_LEN-1:0] wdata_o;
    logic                misalign_o;

    modport slave (
        input  in_valid_i, wd_i, wreg_i, alu_result_i, mem_wdata_i, load_type_i, store_type_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, out_ready_i,
        output in_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output out_valid_o, wd_o, wreg_o, wdata_o, misalign_o
    );

    modport master (
        output in_valid_i, wd_i, wreg_i, alu_result_i, mem_wdata_i, load_type_i, store_type_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, out_ready_i,
        input  in_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  out_valid_o, wd_o, wreg_o, wdata_o, misalign_o
    );
endinterface

// File: rtl/ysyx_22041211_lsu.sv
// Multicycle load/store unit: one instruction in flight, req/gnt/rvalid memory port,
// load alignment/extension and a registered valid/ready result towards writeback.
module ysyx_22041211_lsu #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    ysyx_22041211_lsu_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [2:0] LB  = 3'd1;
    localparam logic [2:0] LBU = 3'd2;
    localparam logic [2:0] LH  = 3'd3;
    localparam logic [2:0] LHU = 3'd4;
    localparam logic [2:0] LW  = 3'd5;
    localparam logic [1:0] SB  = 2'd1;
    localparam logic [1:0] SH  = 2'd2;
    localparam logic [1:0] SW  = 2'd3;

    function automatic logic is_load_type(input logic [2:0] lt);
        return (lt >= LB) && (lt <= LW);
    endfunction

    // A request carrying both a load and a store type is handled as the load.
    function automatic logic check_misalign(input logic [2:0] lt, input logic [1:0] st,
                                            input logic [1:0] off);
        if (is_load_type(lt)) begin
            case (lt)
                LH, LHU: return off[0];
                LW:      return |off;
                default: return 1'b0;
            endcase
        end
        case (st)
            SH:      return off[0];
            SW:      return |off;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] st, input logic [1:0] off);
        case (st)
            SB:      return 4'b0001 << off;
            SH:      return 4'b0011 << off;
            SW:      return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_LEN-1:0] store_data(input logic [1:0] st,
                                                       input logic [DATA_LEN-1:0] d);
        case (st)
            SB:      return {4{d[7:0]}};
            SH:      return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [DATA_LEN-1:0] load_extend(input logic [2:0] lt, input logic [1:0] off,
                                                        input logic [DATA_LEN-1:0] rdata);
        logic [DATA_LEN-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (lt)
            LB:      return {{(DATA_LEN-8){sh[7]}}, sh[7:0]};
            LBU:     return {{(DATA_LEN-8){1'b0}}, sh[7:0]};
            LH:      return {{(DATA_LEN-16){sh[15]}}, sh[15:0]};
            LHU:     return {{(DATA_LEN-16){1'b0}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    state_t              state;
    logic                in_ready_r;
    logic                mem_req_r;
    logic                mem_we_r;
    logic [ADDR_LEN-1:0] mem_addr_r;
    logic [DATA_LEN-1:0] mem_wdata_r;
    logic [3:0]          mem_wstrb_r;
    logic                out_valid_r;
    logic                wd_r;
    logic [4:0]          wreg_r;
    logic [DATA_LEN-1:0] wdata_r;
    logic                misalign_r;

    logic [2:0]          load_type_p0;
    logic [1:0]          off_p0;
    logic                wd_p0;

    logic                accept;
    logic                is_load;
    logic                is_store;
    logic                misaligned;
    logic [1:0]          off;

    always_comb begin
        accept     = in_ready_r && bus.in_valid_i;
        off        = bus.alu_result_i[1:0];
        is_load    = is_load_type(bus.load_type_i);
        is_store   = !is_load && (bus.store_type_i != 2'd0);
        misaligned = check_misalign(bus.load_type_i, bus.store_type_i, off);
    end

    // in_ready_r is a register so it reads 0 while rst is held and rises on the
    // first clean edge in IDLE; acceptance is gated by it, not by the state alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            in_ready_r   <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            mem_wstrb_r  <= '0;
            out_valid_r  <= 1'b0;
            wd_r         <= 1'b0;
            wreg_r       <= '0;
            wdata_r      <= '0;
            misalign_r   <= 1'b0;
            load_type_p0 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (accept) begin
                        in_ready_r   <= 1'b0;
                        load_type_p0 <= bus.load_type_i;
                        off_p0       <= off;
                        wd_p0        <= bus.wd_i;
                        wreg_r       <= bus.wreg_i;
                        misalign_r   <= misaligned;
                        wd_r         <= 1'b0;
                        wdata_r      <= bus.alu_result_i;
                        if (misaligned) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                        end else if (is_load || is_store) begin
                            state       <= REQ;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= is_store;
                            mem_addr_r  <= {bus.alu_result_i[ADDR_LEN-1:2], 2'b00};
                            mem_wdata_r <= is_store ? store_data(bus.store_type_i, bus.mem_wdata_i) : '0;
                            mem_wstrb_r <= is_store ? store_strb(bus.store_type_i, off) : 4'b0000;
                        end else begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            wd_r        <= bus.wd_i;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_gnt_i) begin
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_wstrb_r <= 4'b0000;
                        if (mem_we_r) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            wdata_r     <= '0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid_i) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        wd_r        <= wd_p0;
                        wdata_r     <= load_extend(load_type_p0, off_p0, bus.mem_rdata_i);
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready_r;
    assign bus.mem_req_o   = mem_req_r;
    assign bus.mem_we_o    = mem_we_r;
    assign bus.mem_addr_o  = mem_addr_r;
    assign bus.mem_wdata_o = mem_wdata_r;
    assign bus.mem_wstrb_o = mem_wstrb_r;
    assign bus.out_valid_o = out_valid_r;
    assign bus.wd_o        = wd_r;
    assign bus.wreg_o      = wreg_r;
    assign bus.wdata_o     = wdata_r;
    assign bus.misalign_o  = misalign_r;

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Bench for ysyx_22041211_lsu: directed vector table, reset corner sequences and
// randomized transactions checked against a byte-level behavioural model.
module tb_ysyx_22041211_lsu;

    typedef struct packed {
        logic [2:0]  lt;
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic        wd;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          gd;
        int          rvd;
        int          rdyd;
    } txn_t;

    typedef struct packed {
        int          req_cycles;
        logic [31:0] maddr;
        logic        mwe;
        logic [3:0]  strb;
        logic [31:0] mwdata;
        bit          chk_mwdata;
        int          lat;
        logic        wd;
        logic        mis;
        logic [31:0] wdata;
        bit          chk_wdata;
    } exp_t;

    typedef struct packed {
        txn_t t;
        exp_t e;
    } vec_t;

    typedef struct packed {
        int          req_cycles;
        logic [31:0] maddr;
        logic        mwe;
        logic [3:0]  strb;
        logic [31:0] mwdata;
        bit          req_stable;
        int          lat;
        logic        wd;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        mis;
        bit          done_stable;
        bit          after_ok;
        bit          busy_rdy;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ysyx_22041211_lsu_if bus ();

    ysyx_22041211_lsu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic txn_t mkt(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic wd, input logic [4:0] rd,
                                 input logic [31:0] rdata, input int gd, input int rvd, input int rdyd);
        txn_t t;
        t.lt = lt; t.st = st; t.addr = addr; t.sdata = sdata; t.wd = wd; t.rd = rd;
        t.rdata = rdata; t.gd = gd; t.rvd = rvd; t.rdyd = rdyd;
        return t;
    endfunction

    function automatic exp_t mke(input int req, input logic [31:0] maddr, input logic mwe,
                                 input logic [3:0] strb, input logic [31:0] mwdata, input bit cmw,
                                 input int lat, input logic wd, input logic mis,
                                 input logic [31:0] wdata, input bit cwd);
        exp_t e;
        e.req_cycles = req; e.maddr = maddr; e.mwe = mwe; e.strb = strb; e.mwdata = mwdata;
        e.chk_mwdata = cmw; e.lat = lat; e.wd = wd; e.mis = mis; e.wdata = wdata; e.chk_wdata = cwd;
        return e;
    endfunction

    // Reference: access size and byte offset decide everything, computed with plain arithmetic.
    function automatic exp_t model(input txn_t t);
        exp_t   e;
        bit     ld;
        bit     sto;
        int     size;
        int     off;
        longint span;
        longint v;
        e    = '0;
        ld   = (t.lt >= 1) && (t.lt <= 5);
        sto  = !ld && (t.st != 0);
        off  = int'(t.addr[1:0]);
        size = 1;
        if (ld) size = (t.lt <= 2) ? 1 : (t.lt <= 4) ? 2 : 4;
        else if (sto) size = (t.st == 1) ? 1 : (t.st == 2) ? 2 : 4;
        if ((ld || sto) && (off % size) != 0) begin
            e.lat = 1; e.mis = 1'b1; e.wd = 1'b0;
            return e;
        end
        if (!(ld || sto)) begin
            e.lat = 1; e.wd = t.wd; e.wdata = t.addr; e.chk_wdata = 1'b1;
            return e;
        end
        e.req_cycles = t.gd + 1;
        e.maddr      = t.addr - 32'(off);
        e.mwe        = sto;
        if (sto) begin
            e.strb = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) e.mwdata[8*i +: 8] = 8'(t.sdata >> (8 * (i % size)));
            e.chk_mwdata = 1'b1;
            e.lat = 2 + t.gd;
            e.wd  = 1'b0;
        end else begin
            span = longint'(1) << (8 * size);
            v    = (longint'(t.rdata) >> (8 * off)) % span;
            if ((t.lt == 1 || t.lt == 3) && v >= span / 2) v = v - span;
            e.wdata = 32'(v);
            e.chk_wdata = 1'b1;
            e.lat = 3 + t.gd + t.rvd;
            e.wd  = t.wd;
        end
        return e;
    endfunction

    task automatic wait_ready();
        for (int k = 0; k < 20 && !bus.in_ready_o; k++) begin
            @(posedge clk); #1;
        end
        chk("in_ready_wait", 32'(bus.in_ready_o), 32'd1);
    endtask

    task automatic run_txn(input txn_t t, output obs_t o);
        bit is_store;
        bit granted;
        int gcyc;
        o        = '0;
        is_store = !((t.lt >= 1) && (t.lt <= 5)) && (t.st != 0);
        granted  = 1'b0;
        gcyc     = 0;
        wait_ready();
        bus.in_valid_i   = 1'b1;
        bus.load_type_i  = t.lt;
        bus.store_type_i = t.st;
        bus.alu_result_i = t.addr;
        bus.mem_wdata_i  = t.sdata;
        bus.wd_i         = t.wd;
        bus.wreg_i       = t.rd;
        @(posedge clk); #1;
        bus.in_valid_i   = 1'b0;
        bus.alu_result_i = $urandom;
        bus.mem_wdata_i  = $urandom;
        bus.wd_i         = 1'($urandom);
        bus.wreg_i       = 5'($urandom);
        bus.load_type_i  = 3'($urandom);
        bus.store_type_i = 2'($urandom);
        o.req_stable     = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            if (bus.in_ready_o) o.busy_rdy = 1'b1;
            if (bus.out_valid_o) begin
                o.lat = c;
                break;
            end
            if (bus.mem_req_o) begin
                if (o.req_cycles == 0) begin
                    o.maddr = bus.mem_addr_o; o.mwe = bus.mem_we_o;
                    o.strb = bus.mem_wstrb_o; o.mwdata = bus.mem_wdata_o;
                end else if (o.maddr !== bus.mem_addr_o || o.mwe !== bus.mem_we_o ||
                             o.strb !== bus.mem_wstrb_o || o.mwdata !== bus.mem_wdata_o) begin
                    o.req_stable = 1'b0;
                end
                if (o.req_cycles == t.gd) begin
                    bus.mem_gnt_i = 1'b1;
                    granted = 1'b1;
                    gcyc = c;
                end
                // Stray read data while the request is still pending must be ignored.
                if (!is_store && $urandom_range(0, 1) == 1) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = $urandom;
                end
                o.req_cycles++;
            end else if (granted && !is_store && c == gcyc + 1 + t.rvd) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = t.rdata;
            end
            @(posedge clk); #1;
        end
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        o.wd    = bus.wd_o;
        o.wreg  = bus.wreg_o;
        o.wdata = bus.wdata_o;
        o.mis   = bus.misalign_o;
        o.done_stable = 1'b1;
        if (o.lat != 0) begin
            for (int k = 0; k < t.rdyd; k++) begin
                bus.out_ready_i = 1'b0;
                @(posedge clk); #1;
                if (!bus.out_valid_o || bus.in_ready_o || bus.wd_o !== o.wd || bus.wreg_o !== o.wreg ||
                    bus.wdata_o !== o.wdata || bus.misalign_o !== o.mis)
                    o.done_stable = 1'b0;
            end
            bus.out_ready_i = 1'b1;
            @(posedge clk); #1;
            bus.out_ready_i = 1'b0;
            o.after_ok = !bus.out_valid_o && bus.in_ready_o;
        end
    endtask

    task automatic check_obs(input string p, input txn_t t, input exp_t e, input obs_t o);
        chk({p, ".req_cycles"}, 32'(o.req_cycles), 32'(e.req_cycles));
        if (e.req_cycles > 0) begin
            chk({p, ".mem_addr"}, o.maddr, e.maddr);
            chk({p, ".mem_we"}, 32'(o.mwe), 32'(e.mwe));
            chk({p, ".mem_wstrb"}, 32'(o.strb), 32'(e.strb));
            if (e.chk_mwdata) chk({p, ".mem_wdata"}, o.mwdata, e.mwdata);
            chk({p, ".req_stable"}, 32'(o.req_stable), 32'd1);
        end
        chk({p, ".latency"}, 32'(o.lat), 32'(e.lat));
        chk({p, ".wd"}, 32'(o.wd), 32'(e.wd));
        chk({p, ".misalign"}, 32'(o.mis), 32'(e.mis));
        chk({p, ".wreg"}, 32'(o.wreg), 32'(t.rd));
        if (e.chk_wdata) chk({p, ".wdata"}, o.wdata, e.wdata);
        chk({p, ".done_stable"}, 32'(o.done_stable), 32'd1);
        chk({p, ".handshake"}, 32'(o.after_ok), 32'd1);
        chk({p, ".busy_ready"}, 32'(o.busy_rdy), 32'd0);
    endtask

    vec_t vecs[16];

    initial begin
        obs_t o;
        txn_t t;
        bus.in_valid_i = 1'b0; bus.wd_i = 1'b0; bus.wreg_i = '0; bus.alu_result_i = '0;
        bus.mem_wdata_i = '0; bus.load_type_i = '0; bus.store_type_i = '0;
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0; bus.out_ready_i = 1'b0;

        vecs[0]  = '{t: mkt(3'd0, 2'd0, 32'h0000_1234, 32'h0, 1'b1, 5'd5, 32'h0, 0, 0, 0),
                     e: mke(0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1, 1'b1, 1'b0, 32'h0000_1234, 1'b1)};
        vecs[1]  = '{t: mkt(3'd0, 2'd1, 32'h8000_0003, 32'hAABB_CCDD, 1'b1, 5'd7, 32'h0, 2, 0, 0),
                     e: mke(3, 32'h8000_0000, 1'b1, 4'b1000, 32'hDDDD_DDDD, 1'b1, 4, 1'b0, 1'b0, 32'h0, 1'b0)};
        vecs[2]  = '{t: mkt(3'd1, 2'd0, 32'h8000_0001, 32'h0, 1'b1, 5'd10, 32'h80F1_7F82, 0, 0, 0),
                     e: mke(1, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 1'b0, 3, 1'b1, 1'b0, 32'h0000_007F, 1'b1)};
        vecs[3]  = '{t: mkt(3'd1, 2'd0, 32'h8000_0000, 32'h0, 1'b1, 5'd11, 32'h80F1_7F82, 0, 0, 0),
                     e: mke(1, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 1'b0, 3, 1'b1, 1'b0, 32'hFFFF_FF82, 1'b1)};
        vecs[4]  = '{t: mkt(3'd3, 2'd0, 32'h8000_0002, 32'h0, 1'b1, 5'd12, 32'h80F1_7F82, 0, 0, 0),
                     e: mke(1, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 1'b0, 3, 1'b1, 1'b0, 32'hFFFF_80F1, 1'b1)};
        vecs[5]  = '{t: mkt(3'd4, 2'd0, 32'h8000_0002, 32'h0, 1'b1, 5'd13, 32'h80F1_7F82, 0, 0, 0),
                     e: mke(1, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 1'b0, 3, 1'b1, 1'b0, 32'h0000_80F1, 1'b1)};
        vecs[6]  = '{t: mkt(3'd5, 2'd0, 32'h8000_0000, 32'h0, 1'b1, 5'd14, 32'h80F1_7F82, 1, 1, 0),
                     e: mke(2, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 1'b0, 5, 1'b1, 1'b0, 32'h80F1_7F82, 1'b1)};
        vecs[7]  = '{t: mkt(3'd5, 2'd0, 32'h8000_0002, 32'h0, 1'b1, 5'd15, 32'h0, 0, 0, 0),
                     e: mke(0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1, 1'b0, 1'b1, 32'h0, 1'b0)};
        vecs[8]  = '{t: mkt(3'd5, 2'd0, 32'h8000_0004, 32'h0, 1'b1, 5'd16, 32'h1357_9BDF, 1, 2, 4),
                     e: mke(2, 32'h8000_0004, 1'b0, 4'h0, 32'h0, 1'b0, 6, 1'b1, 1'b0, 32'h1357_9BDF, 1'b1)};
        vecs[9]  = '{t: mkt(3'd0, 2'd2, 32'h1000_0002, 32'h1234_ABCD, 1'b1, 5'd17, 32'h0, 0, 0, 1),
                     e: mke(1, 32'h1000_0000, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b1, 2, 1'b0, 1'b0, 32'h0, 1'b0)};
        vecs[10] = '{t: mkt(3'd0, 2'd3, 32'h1000_0008, 32'hCAFE_F00D, 1'b1, 5'd18, 32'h0, 1, 0, 0),
                     e: mke(2, 32'h1000_0008, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b1, 3, 1'b0, 1'b0, 32'h0, 1'b0)};
        vecs[11] = '{t: mkt(3'd2, 2'd0, 32'h8000_0003, 32'h0, 1'b1, 5'd19, 32'h80F1_7F82, 0, 0, 0),
                     e: mke(1, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 1'b0, 3, 1'b1, 1'b0, 32'h0000_0080, 1'b1)};
        vecs[12] = '{t: mkt(3'd3, 2'd0, 32'h8000_0001, 32'h0, 1'b1, 5'd20, 32'h0, 0, 0, 0),
                     e: mke(0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1, 1'b0, 1'b1, 32'h0, 1'b0)};
        vecs[13] = '{t: mkt(3'd2, 2'd3, 32'h8000_0003, 32'h5555_5555, 1'b1, 5'd21, 32'h80F1_7F82, 0, 0, 0),
                     e: mke(1, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 1'b0, 3, 1'b1, 1'b0, 32'h0000_0080, 1'b1)};
        vecs[14] = '{t: mkt(3'd0, 2'd2, 32'h8000_0003, 32'h0000_BEEF, 1'b1, 5'd22, 32'h0, 0, 0, 0),
                     e: mke(0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1, 1'b0, 1'b1, 32'h0, 1'b0)};
        vecs[15] = '{t: mkt(3'd0, 2'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd31, 32'h0, 0, 0, 2),
                     e: mke(0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1)};

        // Outputs while reset is held
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(bus.in_ready_o), 32'd0);
        chk("rst.mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst.mem_we", 32'(bus.mem_we_o), 32'd0);
        chk("rst.mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst.mem_wdata", bus.mem_wdata_o, 32'd0);
        chk("rst.mem_wstrb", 32'(bus.mem_wstrb_o), 32'd0);
        chk("rst.out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst.wd", 32'(bus.wd_o), 32'd0);
        chk("rst.wreg", 32'(bus.wreg_o), 32'd0);
        chk("rst.wdata", bus.wdata_o, 32'd0);
        chk("rst.misalign", 32'(bus.misalign_o), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_txn(vecs[i].t, o);
            check_obs($sformatf("vec%0d", i), vecs[i].t, vecs[i].e, o);
        end

        // Reset while waiting for read data; a late rvalid must not produce a result.
        wait_ready();
        bus.in_valid_i = 1'b1; bus.load_type_i = 3'd5; bus.store_type_i = 2'd0;
        bus.alu_result_i = 32'h8000_0010; bus.wd_i = 1'b1; bus.wreg_i = 5'd9;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        chk("rstwait.req", 32'(bus.mem_req_o), 32'd1);
        bus.mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt_i = 1'b0;
        chk("rstwait.req_drop", 32'(bus.mem_req_o), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstwait.in_ready_low", 32'(bus.in_ready_o), 32'd0);
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.mem_rvalid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rstwait.out_valid%0d", k), 32'(bus.out_valid_o), 32'd0);
            chk($sformatf("rstwait.mem_req%0d", k), 32'(bus.mem_req_o), 32'd0);
            @(posedge clk); #1;
        end
        chk("rstwait.in_ready", 32'(bus.in_ready_o), 32'd1);

        // Reset while a store request is pending and ungranted.
        bus.in_valid_i = 1'b1; bus.load_type_i = 3'd0; bus.store_type_i = 2'd3;
        bus.alu_result_i = 32'h2000_0000; bus.mem_wdata_i = 32'h0BAD_F00D;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        chk("rstreq.req", 32'(bus.mem_req_o), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstreq.req_drop", 32'(bus.mem_req_o), 32'd0);
        chk("rstreq.out_valid", 32'(bus.out_valid_o), 32'd0);

        for (int n = 0; n < 150; n++) begin
            t.lt    = 3'($urandom_range(0, 5));
            t.st    = 2'($urandom_range(0, 3));
            t.addr  = $urandom;
            t.sdata = $urandom;
            t.wd    = 1'($urandom);
            t.rd    = 5'($urandom);
            t.rdata = $urandom;
            t.gd    = int'($urandom_range(0, 3));
            t.rvd   = int'($urandom_range(0, 3));
            t.rdyd  = int'($urandom_range(0, 2));
            run_txn(t, o);
            check_obs($sformatf("rnd%0d", n), t, model(t), o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
